// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB target among NREQ requesters. Drives the
// APB master side IDLE -> SETUP -> ACCESS with registered outputs and a PREADY timeout.
module apb_master_arbiter #(
   parameter int NREQ    = 2,
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_write,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic [DW-1:0]        rdata,
   output logic                 PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [AW-1:0]        PADDR,
   output logic [DW-1:0]        PWDATA,
   input  logic [DW-1:0]        PRDATA,
   input  logic                 PREADY
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10,
      ST_BAD    = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            psel_q, psel_d;
   logic            penable_q, penable_d;
   logic            pwrite_q, pwrite_d;
   logic [AW-1:0]   paddr_q, paddr_d;
   logic [DW-1:0]   pwdata_q, pwdata_d;
   logic [PW-1:0]   last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [AW-1:0]   addr_arr  [NREQ];
   logic [DW-1:0]   wdata_arr [NREQ];
   logic [NREQ-1:0] win_oh;
   logic [PW-1:0]   win_idx;
   logic            win_write;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_wdata;
   logic            timeout_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*AW +: AW];
         assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
      end
   endgenerate

   generate
      if (TIMEOUT != 0) begin : g_timeout
         assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Search starts one past the last winner, so requester 0 leads after reset.
   always_comb begin
      int   idx;
      logic found;
      idx       = 0;
      found     = 1'b0;
      win_oh    = '0;
      win_idx   = '0;
      win_write = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(last_q) + 1 + k) % NREQ;
         if (!found && req[idx]) begin
            found       = 1'b1;
            win_oh[idx] = 1'b1;
            win_idx     = PW'(idx);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_write = req_write[i];
            win_addr  = addr_arr[i];
            win_wdata = wdata_arr[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      err_d     = 1'b0;
      rdata_d   = '0;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      last_d    = last_q;
      cnt_d     = '0;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d     = win_oh;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = win_write;
               paddr_d   = win_addr;
               pwdata_d  = win_wdata;
               last_d    = win_idx;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               done_d    = gnt_q;
               rdata_d   = pwrite_q ? '0 : PRDATA;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               gnt_d     = '0;
               state_d   = ST_IDLE;
            end else if (timeout_hit) begin
               done_d    = gnt_q;
               err_d     = 1'b1;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               gnt_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            gnt_d     = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         last_q    <= PW'(NREQ - 1);
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rdata   = rdata_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: RAM-backed APB slave with programmable
// PREADY wait states, hand-computed expectations checked by immediate assertions.
module tb_apb_master_arbiter;

   localparam int NREQ    = 2;
   localparam int AW      = 8;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic                 PCLK = 1'b0;
   logic                 PRESET;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      req_write;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_wdata;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      done;
   logic                 err;
   logic [DW-1:0]        rdata;
   logic                 PSEL;
   logic                 PENABLE;
   logic                 PWRITE;
   logic [AW-1:0]        PADDR;
   logic [DW-1:0]        PWDATA;
   logic [DW-1:0]        PRDATA;
   logic                 PREADY;

   bit [31:0] mem [256];
   bit        vld [256];
   int        wait_cfg = 0;
   bit        dead     = 1'b0;
   int        wcnt     = 0;

   int n_assert = 0;
   int n_fail   = 0;

   int          ord    [4] = '{0, 1, 0, 1};
   logic [31:0] exp_rd [2] = '{32'hA5A5_A520, 32'hA5A5_A521};
   logic [1:0]  g;

   apb_master_arbiter #(
      .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   // Slave: unwritten locations read back a pattern carrying their address.
   assign PREADY = PSEL && PENABLE && !dead && (wcnt == wait_cfg);
   assign PRDATA = vld[PADDR] ? mem[PADDR] : {24'hA5A5A5, PADDR};

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE) begin
         mem[PADDR] <= PWDATA;
         vld[PADDR] <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
      req_write[i]           = w;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
      req[i]                 = 1'b1;
   endtask

   initial begin
      req       = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      PRESET    = 1'b1;
      repeat (2) tick();
      chk("rst_psel",    PSEL,    0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_gnt",     gnt,     0);
      chk("rst_done",    done,    0);
      chk("rst_err",     err,     0);
      chk("rst_rdata",   rdata,   0);
      chk("rst_paddr",   PADDR,   0);
      chk("rst_pwdata",  PWDATA,  0);
      chk("rst_pwrite",  PWRITE,  0);
      PRESET = 1'b0;
      $display("reset released");

      // Zero-wait write then read of 0x12
      drive(0, 1'b1, 8'h12, 32'hDEAD_BEEF);
      tick();
      chk("wr_c1_psel",    PSEL,    1);
      chk("wr_c1_penable", PENABLE, 0);
      chk("wr_c1_gnt",     gnt,     2'b01);
      chk("wr_c1_paddr",   PADDR,   8'h12);
      chk("wr_c1_pwdata",  PWDATA,  32'hDEAD_BEEF);
      chk("wr_c1_pwrite",  PWRITE,  1);
      tick();
      chk("wr_c2_psel",    PSEL,    1);
      chk("wr_c2_penable", PENABLE, 1);
      chk("wr_c2_done",    done,    0);
      tick();
      chk("wr_c3_done",    done,    2'b01);
      chk("wr_c3_err",     err,     0);
      chk("wr_c3_rdata",   rdata,   0);
      chk("wr_c3_psel",    PSEL,    0);
      chk("wr_c3_gnt",     gnt,     0);
      req = '0;
      tick();
      chk("wr_c4_done",    done,    0);
      chk("wr_c4_psel",    PSEL,    0);
      $display("write 0x12 <= deadbeef complete");

      drive(0, 1'b0, 8'h12, 32'h0);
      tick();
      chk("rd_c1_psel",    PSEL,    1);
      chk("rd_c1_pwrite",  PWRITE,  0);
      tick();
      chk("rd_c2_penable", PENABLE, 1);
      tick();
      chk("rd_c3_done",    done,    2'b01);
      chk("rd_c3_rdata",   rdata,   32'hDEAD_BEEF);
      chk("rd_c3_err",     err,     0);
      req = '0;
      tick();
      chk("rd_c4_done",    done,    0);
      chk("rd_c4_rdata",   rdata,   0);
      $display("read 0x12 rdata=%08h", 32'hDEAD_BEEF);

      // Reset asserted mid-ACCESS aborts without done
      wait_cfg = 5;
      drive(1, 1'b0, 8'h21, 32'h0);
      tick();
      chk("mr_gnt",        gnt,     2'b10);
      tick();
      tick();
      chk("mr_in_access",  PENABLE, 1);
      PRESET = 1'b1;
      tick();
      chk("mr_psel",       PSEL,    0);
      chk("mr_penable",    PENABLE, 0);
      chk("mr_gnt0",       gnt,     0);
      chk("mr_done",       done,    0);
      req      = '0;
      wait_cfg = 0;
      PRESET   = 1'b0;
      tick();
      chk("mr_after_done", done,    0);
      $display("reset mid-access aborted");

      // Both requesters held: grants alternate starting with requester 0
      drive(0, 1'b0, 8'h20, 32'h0);
      drive(1, 1'b0, 8'h21, 32'h0);
      for (int t = 0; t < 4; t++) begin
         g = 2'b01 << ord[t];
         tick();
         chk("rr_gnt",     gnt,     g);
         chk("rr_psel",    PSEL,    1);
         chk("rr_penable", PENABLE, 0);
         chk("rr_done_lo", done,    0);
         tick();
         chk("rr_access",  PENABLE, 1);
         tick();
         chk("rr_done",    done,    g);
         chk("rr_rdata",   rdata,   exp_rd[ord[t]]);
         chk("rr_gap",     PSEL,    0);
         if (t == 3) req = '0;
         $display("rr transfer %0d granted requester %0d", t, ord[t]);
      end
      tick();
      chk("rr_end_done",   done,    0);
      chk("rr_end_psel",   PSEL,    0);

      // PREADY held low for 3 ACCESS cycles
      wait_cfg = 3;
      drive(0, 1'b1, 8'h30, 32'hCAFE_F00D);
      tick();
      chk("ws_gnt",        gnt,     2'b01);
      for (int c = 2; c <= 5; c++) begin
         tick();
         chk("ws_penable",  PENABLE, 1);
         chk("ws_paddr",    PADDR,   8'h30);
         chk("ws_pwdata",   PWDATA,  32'hCAFE_F00D);
         chk("ws_done_lo",  done,    0);
      end
      tick();
      chk("ws_done",       done,    2'b01);
      chk("ws_err",        err,     0);
      req      = '0;
      wait_cfg = 0;
      $display("wait-state write done at latency 6");

      // Dead slave: timeout after 16 ACCESS cycles
      dead = 1'b1;
      drive(1, 1'b0, 8'h40, 32'h0);
      tick();
      chk("to_gnt",        gnt,     2'b10);
      tick();
      chk("to_entry",      PENABLE, 1);
      for (int c = 3; c <= 17; c++) begin
         tick();
         chk("to_done_lo",  done,    0);
      end
      tick();
      chk("to_done",       done,    2'b10);
      chk("to_err",        err,     1);
      chk("to_rdata",      rdata,   0);
      chk("to_psel",       PSEL,    0);
      chk("to_gnt0",       gnt,     0);
      req  = '0;
      dead = 1'b0;
      tick();
      chk("to_err_clr",    err,     0);
      chk("to_done_clr",   done,    0);
      $display("timeout transfer reported err");

      drive(0, 1'b0, 8'h30, 32'h0);
      tick();
      tick();
      tick();
      chk("post_done",     done,    2'b01);
      chk("post_rdata",    rdata,   32'hCAFE_F00D);
      chk("post_err",      err,     0);
      req = '0;
      tick();
      $display("post-timeout read 0x30 complete");

      // Requester 1 drops req during SETUP
      drive(1, 1'b1, 8'h50, 32'h0BAD_C0DE);
      tick();
      chk("dr_gnt",        gnt,     2'b10);
      chk("dr_penable",    PENABLE, 0);
      req[1] = 1'b0;
      tick();
      chk("dr_access",     PENABLE, 1);
      tick();
      chk("dr_done",       done,    2'b10);
      chk("dr_err",        err,     0);
      tick();
      chk("dr_idle_psel",  PSEL,    0);
      chk("dr_done_clr",   done,    0);
      tick();
      chk("dr_no_new",     PSEL,    0);
      chk("dr_mem",        mem[8'h50], 32'h0BAD_C0DE);
      $display("dropped-req transfer complete");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
